// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Signed operands are divided as magnitudes and the sign is restored in FIX.
module iter_divider #(
    parameter int XLEN = 64,
    parameter int TIDW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [TIDW-1:0] tid_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [TIDW-1:0] tid_out
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t state, state_next;

    logic [1:0]      op_r;
    logic [TIDW-1:0] tid_r;
    logic [XLEN-1:0] dvd;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] divisor;
    logic [CW-1:0]   cnt;
    logic            q_neg;
    logic            r_neg;
    logic            special;

    logic            accept;
    logic            is_signed;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] fix_val;
    logic            fix_neg;

    always_comb begin
        accept    = start && (state == IDLE || state == DONE);
        is_signed = !op[0];
        div_zero  = (B == '0);
        overflow  = is_signed && (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
        a_abs     = (is_signed && A[XLEN-1]) ? -A : A;
        b_abs     = (is_signed && B[XLEN-1]) ? -B : B;
        // Bit XLEN of the 65-bit trial is set exactly when the subtraction underflows.
        shifted   = {rem, dvd[XLEN-1]};
        trial     = shifted - {1'b0, divisor};
        fix_val   = op_r[1] ? rem : dvd;
        fix_neg   = !special && !op_r[0] && (op_r[1] ? r_neg : q_neg);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (div_zero || overflow) ? FIX : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (accept) begin
                    state_next = (div_zero || overflow) ? FIX : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Special cases preload quotient (dvd) and remainder (rem) with their final values.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r    <= '0;
            tid_r   <= '0;
            dvd     <= '0;
            rem     <= '0;
            divisor <= '0;
            cnt     <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            special <= 1'b0;
            result  <= '0;
            tid_out <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        op_r    <= op;
                        tid_r   <= tid_in;
                        cnt     <= CW'(XLEN - 1);
                        divisor <= b_abs;
                        q_neg   <= is_signed && (A[XLEN-1] ^ B[XLEN-1]);
                        r_neg   <= is_signed && A[XLEN-1];
                        special <= div_zero || overflow;
                        if (div_zero) begin
                            dvd <= '1;
                            rem <= A;
                        end else if (overflow) begin
                            dvd <= A;
                            rem <= '0;
                        end else begin
                            dvd <= a_abs;
                            rem <= '0;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (!trial[XLEN]) begin
                        rem <= trial[XLEN-1:0];
                        dvd <= {dvd[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= shifted[XLEN-1:0];
                        dvd <= {dvd[XLEN-2:0], 1'b0};
                    end
                end
                FIX: begin
                    result  <= fix_neg ? -fix_val : fix_val;
                    tid_out <= tid_r;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard testbench for iter_divider: a RISC-V M reference model predicts each
// result, tag and done latency; a negedge monitor pops and compares on every done.
module tb_iter_divider;

    localparam int XLEN = 64;
    localparam int TIDW = 2;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [TIDW-1:0] tid_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [TIDW-1:0] tid_out;

    typedef struct {
        logic [63:0] res;
        logic [1:0]  tid;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;

    iter_divider #(.XLEN(XLEN), .TIDW(TIDW)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .A       (a),
        .B       (b),
        .tid_in  (tid_in),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .tid_out (tid_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit isSpecial(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
        return (y == 64'd0) || (!o[0] && x == MINV && y == '1);
    endfunction

    // RISC-V M semantics: truncating quotient, remainder signed like the dividend.
    function automatic logic [63:0] refModel(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        if (y == 64'd0) return o[1] ? x : '1;
        if (!o[0] && x == MINV && y == '1) return o[1] ? 64'd0 : x;
        sx = x;
        sy = y;
        case (o)
            2'd0:    return sx / sy;
            2'd1:    return x / y;
            2'd2:    return sx % sy;
            default: return x % y;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_done: got done=1 result=0x%h tid=%0d, expected no pending op",
                         result, tid_out);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("sb_result", result, mon_e.res);
                checkOutput("sb_tid", 64'(tid_out), 64'(mon_e.tid));
                checkOutput("sb_latency", 64'(cyc - mon_e.acc + 1), 64'(mon_e.lat));
            end
        end
    end

    // Called #1 after a rising edge; issues one request as soon as busy is low.
    task automatic applyStimulus(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                                 input logic [1:0] t);
        int n = 0;
        while (busy !== 1'b0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) begin
            checks++;
            $display("[TB] FAIL issue_timeout: got busy=%b, expected 0 within 300 cycles", busy);
        end
        op = o; a = x; b = y; tid_in = t; start = 1'b1;
        @(posedge clk); #1;
        sb.push_back('{res: refModel(o, x, y), tid: t, lat: isSpecial(o, x, y) ? 2 : 66, acc: cyc});
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic waitDone(output int when);
        int n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) begin
            checks++;
            $display("[TB] FAIL done_timeout: got done=%b, expected 1 within 300 cycles", done);
        end
        when = cyc;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] qa[4];
        logic [63:0] qb[4];
        logic [63:0] qdiv[4];
        logic [63:0] qrem[4];
        int          first_done;
        int          second_done;

        qa   = '{64'd7, 64'd7, -64'd7, -64'd7};
        qb   = '{64'd2, -64'd2, 64'd2, -64'd2};
        qdiv = '{64'd3, -64'd3, -64'd3, 64'd3};
        qrem = '{64'd1, 64'd1, -64'd1, -64'd1};

        reset = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0; tid_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_result", result, 64'd0);
        checkOutput("reset_tid", 64'(tid_out), 64'd0);
        reset = 1'b0;

        // Abort DIVU 100/7 mid-RUN; it must never produce a done pulse.
        applyStimulus(2'd1, 64'd100, 64'd7, 2'd2);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_result", result, 64'd0);
        reset = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        checkOutput("abort_idle_busy", 64'(busy), 64'd0);

        applyStimulus(2'd1, 64'd100, 64'd7, 2'd2);
        drain();
        checkOutput("divu_100_7", result, 64'd14);
        checkOutput("divu_tid", 64'(tid_out), 64'd2);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("result_held", result, 64'd14);

        applyStimulus(2'd3, 64'd100, 64'd7, 2'd1);
        drain();
        checkOutput("remu_100_7", result, 64'd2);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'd0, qa[i], qb[i], 2'(i));
            drain();
            checkOutput("quad_div", result, qdiv[i]);
            applyStimulus(2'd2, qa[i], qb[i], 2'(i));
            drain();
            checkOutput("quad_rem", result, qrem[i]);
        end

        applyStimulus(2'd1, 64'd5, 64'd0, 2'd3);
        drain();
        checkOutput("divu_by_zero", result, 64'hFFFF_FFFF_FFFF_FFFF);
        applyStimulus(2'd2, -64'd9, 64'd0, 2'd0);
        drain();
        checkOutput("rem_by_zero", result, -64'd9);
        applyStimulus(2'd0, MINV, '1, 2'd1);
        drain();
        checkOutput("div_overflow", result, MINV);
        applyStimulus(2'd2, MINV, '1, 2'd2);
        drain();
        checkOutput("rem_overflow", result, 64'd0);

        // start held high: the operands change while busy, only the DONE-cycle accept sees them.
        op = 2'd1; a = 64'd100; b = 64'd7; tid_in = 2'd1; start = 1'b1;
        @(posedge clk); #1;
        sb.push_back('{res: 64'd14, tid: 2'd1, lat: 66, acc: cyc});
        a = '1; b = 64'd1; tid_in = 2'd3;
        waitDone(first_done);
        @(posedge clk); #1;
        sb.push_back('{res: 64'hFFFF_FFFF_FFFF_FFFF, tid: 2'd3, lat: 66, acc: cyc});
        start = 1'b0;
        waitDone(second_done);
        checkOutput("b2b_gap", 64'(second_done - first_done), 64'd66);
        drain();
        checkOutput("b2b_result", result, 64'hFFFF_FFFF_FFFF_FFFF);

        applyStimulus(2'd0, -64'd100, 64'd7, 2'd0);
        repeat (20) @(posedge clk);
        #1;
        op = 2'd3; a = 64'd55; b = 64'd4; tid_in = 2'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drain();
        checkOutput("midrun_ignored", result, -64'd14);
        checkOutput("midrun_tid", 64'(tid_out), 64'd0);

        for (int i = 0; i < 16; i++) begin
            logic [1:0]  ro;
            logic [63:0] rx;
            logic [63:0] ry;
            ro = 2'($urandom_range(0, 3));
            rx = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0:       ry = 64'd0;
                1:       ry = 64'($urandom_range(1, 15));
                2:       ry = '1;
                3:       begin rx = MINV; ry = '1; end
                default: ry = {$urandom, $urandom} >> $urandom_range(0, 63);
            endcase
            applyStimulus(ro, rx, ry, 2'($urandom_range(0, 3)));
        end
        drain();
        repeat (5) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
